// File: rtl/mycpu_pkg.sv
// Shared CPU definitions: forwarding-source indices, default datapath sizes
// and the flattened-bus slice helper macro.
`ifndef MYCPU_PKG_SV
`define MYCPU_PKG_SV

// Slice element idx of width w out of a flattened bus.
`define MYCPU_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package mycpu_pkg;

    localparam int MYCPU_XLEN = 32;
    localparam int MYCPU_NREG = 32;

    // Index 0 is the youngest stage; higher indices are older.
    typedef enum int {
        FWD_EXE = 0,
        FWD_MEM = 1,
        FWD_WB  = 2
    } fwd_src_e;

    localparam int MYCPU_NFWD = int'(FWD_WB) + 1;

endpackage

`endif

// File: rtl/ds_scoreboard_if.sv
// Pipeline-to-scoreboard bundle: per-stage forwarding buses plus the
// writeback retire strobe.
interface ds_scoreboard_if
    import mycpu_pkg::*;
#(
    parameter int XLEN = MYCPU_XLEN,
    parameter int NREG = MYCPU_NREG,
    parameter int NFWD = MYCPU_NFWD
);
    localparam int AW = $clog2(NREG);

    logic [NFWD-1:0]      fwd_valid;
    logic [NFWD-1:0]      fwd_we;
    logic [NFWD*AW-1:0]   fwd_dest;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic [NFWD-1:0]      fwd_ok;
    logic                 ws_we;
    logic [AW-1:0]        ws_waddr;

    modport master (
        output fwd_valid, fwd_we, fwd_dest, fwd_data, fwd_ok, ws_we, ws_waddr
    );

    modport slave (
        input fwd_valid, fwd_we, fwd_dest, fwd_data, fwd_ok, ws_we, ws_waddr
    );
endinterface

// File: rtl/ds_scoreboard_fwd_mux.sv
// ds_fwd_mux: single read-port operand resolver. Picks the youngest matching
// forwarding stage when the register is pending, otherwise the regfile value.
module ds_fwd_mux
    import mycpu_pkg::*;
#(
    parameter int XLEN = MYCPU_XLEN,
    parameter int AW   = 5,
    parameter int NFWD = MYCPU_NFWD
) (
    input  logic [AW-1:0]        addr,
    input  logic [XLEN-1:0]      rf_rdata,
    input  logic                 pend_nz,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD*AW-1:0]   fwd_dest,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic [NFWD-1:0]      fwd_ok,
    output logic [XLEN-1:0]      data,
    output logic                 resolved
);

    logic            hit;
    logic            hit_ok;
    logic [XLEN-1:0] hit_data;

    always_comb begin
        hit      = 1'b0;
        hit_ok   = 1'b0;
        hit_data = '0;
        // Walk oldest to youngest so the youngest match is the one kept.
        for (int j = NFWD - 1; j >= int'(FWD_EXE); j--) begin
            if (fwd_valid[j] && fwd_we[j] && `MYCPU_SLICE(fwd_dest, j, AW) == addr) begin
                hit      = 1'b1;
                hit_ok   = fwd_ok[j];
                hit_data = `MYCPU_SLICE(fwd_data, j, XLEN);
            end
        end
    end

    always_comb begin
        data     = rf_rdata;
        resolved = 1'b1;
        if (addr == '0) begin
            data = '0;
        end else if (pend_nz) begin
            if (hit && hit_ok) begin
                data = hit_data;
            end else begin
                resolved = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ds_scoreboard.sv
// Decode-stage register scoreboard with in-flight write counters, forwarding
// and load-use interlock. Optional macro DS_SB_STALL_CNT_EN adds stall_cnt.
module ds_scoreboard
    import mycpu_pkg::*;
#(
    parameter int XLEN = MYCPU_XLEN,
    parameter int NREG = MYCPU_NREG,
    parameter int NRD  = 2,
    parameter int NFWD = MYCPU_NFWD,
    parameter int CW   = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ds_valid,
    input  logic [NRD*AW-1:0]    rd_addr,
    input  logic [NRD*XLEN-1:0]  rf_rdata,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic                 ds_ready_go,
    input  logic                 ds_issue,
    input  logic                 ds_gr_we,
    input  logic [AW-1:0]        ds_dest,
    ds_scoreboard_if.slave       pipe,
    input  logic                 flush,
    output logic                 sb_err
`ifdef DS_SB_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam logic [CW-1:0] PEND_MAX = '1;

    logic [CW-1:0]   pend [NREG];
    logic [NREG-1:0] inc;
    logic [NREG-1:0] dec;
    logic [NREG-1:0] at_max;
    logic [NREG-1:0] at_zero;
    logic            err_ev;
    logic [NRD-1:0]  pend_nz;
    logic [NRD-1:0]  resolved;
    logic            sat_stall;

    for (genvar i = 0; i < NRD; i++) begin : g_port
        logic [AW-1:0] a;
        assign a          = `MYCPU_SLICE(rd_addr, i, AW);
        assign pend_nz[i] = (pend[a] != '0);

        ds_fwd_mux #(
            .XLEN (XLEN),
            .AW   (AW),
            .NFWD (NFWD)
        ) u_fwd_mux (
            .addr      (a),
            .rf_rdata  (`MYCPU_SLICE(rf_rdata, i, XLEN)),
            .pend_nz   (pend_nz[i]),
            .fwd_valid (pipe.fwd_valid),
            .fwd_we    (pipe.fwd_we),
            .fwd_dest  (pipe.fwd_dest),
            .fwd_data  (pipe.fwd_data),
            .fwd_ok    (pipe.fwd_ok),
            .data      (`MYCPU_SLICE(rd_data, i, XLEN)),
            .resolved  (resolved[i])
        );
    end

    // A writer whose destination counter is already full must wait.
    assign sat_stall   = ds_gr_we && (ds_dest != '0) && (pend[ds_dest] == PEND_MAX);
    assign ds_ready_go = (&resolved) && !sat_stall;

    always_comb begin
        inc     = '0;
        dec     = '0;
        at_max  = '0;
        at_zero = '0;
        for (int r = 1; r < NREG; r++) begin
            inc[r]     = ds_issue && ds_gr_we && (ds_dest == AW'(r));
            dec[r]     = pipe.ws_we && (pipe.ws_waddr == AW'(r));
            at_max[r]  = (pend[r] == PEND_MAX);
            at_zero[r] = (pend[r] == '0);
        end
    end

    assign err_ev = (|(inc & ~dec & at_max)) || (|(dec & ~inc & at_zero));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) begin
                pend[r] <= '0;
            end
        end else if (flush) begin
            for (int r = 1; r < NREG; r++) begin
                pend[r] <= '0;
            end
        end else begin
            // Out-of-range updates leave the counter holding; sb_err records them.
            for (int r = 1; r < NREG; r++) begin
                if (inc[r] && !dec[r] && !at_max[r]) begin
                    pend[r] <= pend[r] + 1'b1;
                end else if (dec[r] && !inc[r] && !at_zero[r]) begin
                    pend[r] <= pend[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sb_err <= 1'b0;
        end else if (!flush && err_ev) begin
            sb_err <= 1'b1;
        end
    end

`ifdef DS_SB_STALL_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (ds_valid && !ds_ready_go) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    logic unused_ds_valid;
    assign unused_ds_valid = ds_valid;
`endif

endmodule
